// File: rtl/cu_fsm.sv
// cu_fsm: multi-cycle control unit sequencer.
// States INIT -> FETCH -> EXEC -> (WB) -> [INTR] -> FETCH. Strobes are
// decoded combinationally from the registered state, the opcode/funct3
// fields and mem_valid.
// Optional feature: define CU_FSM_INTR_EN to build the INTR state and the
// intr/mie sampling; otherwise interrupts are ignored and int_taken is 0.
module cu_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] ir6_0,
   input  logic [2:0] ir14_12,
   input  logic       intr,
   input  logic       mie,
   input  logic       mem_valid,
   output logic       pcWrite,
   output logic       regWrite,
   output logic       memWE2,
   output logic       memRDEN1,
   output logic       memRDEN2,
   output logic       reset,
   output logic       csr_WE,
   output logic       int_taken,
   output logic       mret_exec,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WB    = 3'd3,
      ST_INTR  = 3'd4
   } state_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   state_e state_r;
   state_e done_next_s;

`ifdef CU_FSM_INTR_EN
   // Destination after an instruction completes: take a pending enabled interrupt
   always_comb begin
      if (intr && mie) begin
         done_next_s = ST_INTR;
      end else begin
         done_next_s = ST_FETCH;
      end
   end
`else
   logic unused_intr_s;
   assign unused_intr_s = intr | mie;

   // Without interrupt support every completed instruction returns to FETCH
   always_comb begin
      done_next_s = ST_FETCH;
   end
`endif

   // State register with synchronous reset; illegal encodings recover to INIT
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_INIT;
      end else begin
         case (state_r)
            ST_INIT:  state_r <= ST_FETCH;
            ST_FETCH: state_r <= ST_EXEC;
            ST_EXEC: begin
               if (ir6_0 == OPC_LOAD) begin
                  state_r <= ST_WB;
               end else begin
                  state_r <= done_next_s;
               end
            end
            ST_WB: begin
               if (mem_valid) begin
                  state_r <= done_next_s;
               end else begin
                  state_r <= ST_WB;
               end
            end
`ifdef CU_FSM_INTR_EN
            ST_INTR:  state_r <= ST_FETCH;
`endif
            default:  state_r <= ST_INIT;
         endcase
      end
   end

   // Strobe decode from current state, opcode, funct3 and load data valid
   always_comb begin
      pcWrite   = 1'b0;
      regWrite  = 1'b0;
      memWE2    = 1'b0;
      memRDEN1  = 1'b0;
      memRDEN2  = 1'b0;
      reset     = 1'b0;
      csr_WE    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;
      case (state_r)
         ST_INIT:  reset    = 1'b1;
         ST_FETCH: memRDEN1 = 1'b1;
         ST_EXEC: begin
            case (ir6_0)
               OPC_LOAD: memRDEN2 = 1'b1;
               OPC_STORE: begin
                  memWE2  = 1'b1;
                  pcWrite = 1'b1;
               end
               OPC_BRANCH: pcWrite = 1'b1;
               OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                  pcWrite  = 1'b1;
                  regWrite = 1'b1;
               end
               OPC_SYSTEM: begin
                  pcWrite = 1'b1;
                  case (ir14_12)
                     3'b001, 3'b010, 3'b011: begin
                        csr_WE   = 1'b1;
                        regWrite = 1'b1;
                     end
                     3'b000:  mret_exec = 1'b1;
                     default: mret_exec = 1'b0;
                  endcase
               end
               // Unknown opcodes retire as a NOP: advance the PC, write nothing
               default: pcWrite = 1'b1;
            endcase
         end
         ST_WB: begin
            if (mem_valid) begin
               regWrite = 1'b1;
               pcWrite  = 1'b1;
            end else begin
               regWrite = 1'b0;
               pcWrite  = 1'b0;
            end
         end
`ifdef CU_FSM_INTR_EN
         ST_INTR: begin
            int_taken = 1'b1;
            pcWrite   = 1'b1;
         end
`endif
         default: reset = 1'b0;
      endcase
   end

   assign state = state_r;

endmodule

// File: tb/tb_cu_fsm.sv
// tb_cu_fsm: directed scoreboard bench for cu_fsm.
// Each step drives inputs on the falling edge, pushes the expected
// {state, strobes} vector, then pops and compares once outputs settle.
module tb_cu_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] ir6_0 = 7'd0;
   logic [2:0] ir14_12 = 3'd0;
   logic       intr = 1'b0;
   logic       mie = 1'b0;
   logic       mem_valid = 1'b0;
   logic       pcWrite, regWrite, memWE2, memRDEN1, memRDEN2;
   logic       reset, csr_WE, int_taken, mret_exec;
   logic [2:0] state;

   int checks = 0;
   int failures = 0;

   logic [11:0] exp_q[$];
   string       tag_q[$];

   // expected vector fields: state in [11:9], strobes in [8:0]
   localparam logic [11:0] S_INIT  = 12'h000;
   localparam logic [11:0] S_FETCH = 12'h200;
   localparam logic [11:0] S_EXEC  = 12'h400;
   localparam logic [11:0] S_WB    = 12'h600;
   localparam logic [11:0] S_INTR  = 12'h800;
   localparam logic [11:0] PC = 12'h100;
   localparam logic [11:0] RW = 12'h080;
   localparam logic [11:0] WE = 12'h040;
   localparam logic [11:0] R1 = 12'h020;
   localparam logic [11:0] R2 = 12'h010;
   localparam logic [11:0] RS = 12'h008;
   localparam logic [11:0] CW = 12'h004;
   localparam logic [11:0] IT = 12'h002;
   localparam logic [11:0] MR = 12'h001;

   localparam logic [6:0] LOAD  = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011;
   localparam logic [6:0] BRNCH = 7'b1100011;
   localparam logic [6:0] OP    = 7'b0110011;
   localparam logic [6:0] LUI   = 7'b0110111;
   localparam logic [6:0] SYS   = 7'b1110011;
   localparam logic [6:0] UNK   = 7'b0000000;

   cu_fsm dut (
      .clk(clk), .rst(rst), .ir6_0(ir6_0), .ir14_12(ir14_12),
      .intr(intr), .mie(mie), .mem_valid(mem_valid),
      .pcWrite(pcWrite), .regWrite(regWrite), .memWE2(memWE2),
      .memRDEN1(memRDEN1), .memRDEN2(memRDEN2), .reset(reset),
      .csr_WE(csr_WE), .int_taken(int_taken), .mret_exec(mret_exec),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic cyc(input string tag, input logic r, input logic [6:0] op,
                      input logic [2:0] f3, input logic i, input logic m,
                      input logic v, input logic [11:0] expv);
      logic [11:0] obs;
      logic [11:0] e;
      string       t;
      @(negedge clk);
      rst = r; ir6_0 = op; ir14_12 = f3; intr = i; mie = m; mem_valid = v;
      exp_q.push_back(expv);
      tag_q.push_back(tag);
      #2;
      obs = {state, pcWrite, regWrite, memWE2, memRDEN1, memRDEN2,
             reset, csr_WE, int_taken, mret_exec};
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (obs === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
   endtask

   initial begin
      // reset held two cycles, then release
      cyc("rst_hold0", 1'b1, OP, 3'd0, 1'b0, 1'b0, 1'b0, S_INIT | RS);
      cyc("rst_hold1", 1'b1, OP, 3'd0, 1'b0, 1'b0, 1'b0, S_INIT | RS);
      cyc("init",      1'b0, OP, 3'd0, 1'b0, 1'b0, 1'b0, S_INIT | RS);
      cyc("fetch0",    1'b0, OP, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | R1);
      cyc("exec_op",   1'b0, OP, 3'd0, 1'b0, 1'b0, 1'b0, S_EXEC | PC | RW);
      // load with three idle WB cycles
      cyc("fetch_ld",  1'b0, LOAD, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | R1);
      cyc("exec_ld",   1'b0, LOAD, 3'd0, 1'b0, 1'b0, 1'b0, S_EXEC | R2);
      cyc("wb_wait0",  1'b0, LOAD, 3'd0, 1'b1, 1'b1, 1'b0, S_WB);
      cyc("wb_wait1",  1'b0, LOAD, 3'd0, 1'b0, 1'b0, 1'b0, S_WB);
      cyc("wb_wait2",  1'b0, LOAD, 3'd0, 1'b0, 1'b0, 1'b0, S_WB);
      cyc("wb_done",   1'b0, LOAD, 3'd0, 1'b0, 1'b0, 1'b1, S_WB | PC | RW);
      // interrupt pending and enabled at EXEC (intr in FETCH is ignored)
      cyc("fetch_i",   1'b0, OP, 3'd0, 1'b1, 1'b1, 1'b0, S_FETCH | R1);
      cyc("exec_i",    1'b0, OP, 3'd0, 1'b1, 1'b1, 1'b0, S_EXEC | PC | RW);
`ifdef CU_FSM_INTR_EN
      cyc("intr",      1'b0, OP, 3'd0, 1'b1, 1'b1, 1'b0, S_INTR | IT | PC);
`endif
      cyc("fetch_ai",  1'b0, OP, 3'd0, 1'b1, 1'b1, 1'b0, S_FETCH | R1);
      // interrupt pending but masked
      cyc("exec_mie0", 1'b0, OP, 3'd0, 1'b1, 1'b0, 1'b0, S_EXEC | PC | RW);
      cyc("fetch_m0",  1'b0, SYS, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | R1);
      // SYSTEM variants
      cyc("exec_mret", 1'b0, SYS, 3'b000, 1'b0, 1'b0, 1'b0, S_EXEC | PC | MR);
      cyc("fetch_s1",  1'b0, SYS, 3'b001, 1'b0, 1'b0, 1'b0, S_FETCH | R1);
      cyc("exec_csrw", 1'b0, SYS, 3'b001, 1'b0, 1'b0, 1'b0, S_EXEC | PC | CW | RW);
      cyc("fetch_s2",  1'b0, SYS, 3'b011, 1'b0, 1'b0, 1'b0, S_FETCH | R1);
      cyc("exec_csrc", 1'b0, SYS, 3'b011, 1'b0, 1'b0, 1'b0, S_EXEC | PC | CW | RW);
      cyc("fetch_s3",  1'b0, SYS, 3'b100, 1'b0, 1'b0, 1'b0, S_FETCH | R1);
      cyc("exec_sys4", 1'b0, SYS, 3'b100, 1'b0, 1'b0, 1'b0, S_EXEC | PC);
      // store, branch, unknown, LUI
      cyc("fetch_st",  1'b0, STORE, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | R1);
      cyc("exec_st",   1'b0, STORE, 3'd0, 1'b0, 1'b0, 1'b0, S_EXEC | PC | WE);
      cyc("fetch_br",  1'b0, BRNCH, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | R1);
      cyc("exec_br",   1'b0, BRNCH, 3'd0, 1'b0, 1'b0, 1'b0, S_EXEC | PC);
      cyc("fetch_unk", 1'b0, UNK, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | R1);
      cyc("exec_unk",  1'b0, UNK, 3'd0, 1'b0, 1'b0, 1'b0, S_EXEC | PC);
      cyc("fetch_lui", 1'b0, LUI, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | R1);
      cyc("exec_lui",  1'b0, LUI, 3'd0, 1'b0, 1'b0, 1'b0, S_EXEC | PC | RW);
      // load completing with interrupt pending
      cyc("fetch_li",  1'b0, LOAD, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | R1);
      cyc("exec_li",   1'b0, LOAD, 3'd0, 1'b0, 1'b0, 1'b0, S_EXEC | R2);
      cyc("wb_intr",   1'b0, LOAD, 3'd0, 1'b1, 1'b1, 1'b1, S_WB | PC | RW);
`ifdef CU_FSM_INTR_EN
      cyc("intr_wb",   1'b0, LOAD, 3'd0, 1'b0, 1'b0, 1'b0, S_INTR | IT | PC);
`endif
      // reset during WB wait aborts the load
      cyc("fetch_ab",  1'b0, LOAD, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | R1);
      cyc("exec_ab",   1'b0, LOAD, 3'd0, 1'b0, 1'b0, 1'b0, S_EXEC | R2);
      cyc("wb_ab0",    1'b0, LOAD, 3'd0, 1'b0, 1'b0, 1'b0, S_WB);
      cyc("wb_ab_rst", 1'b1, LOAD, 3'd0, 1'b0, 1'b0, 1'b0, S_WB);
      cyc("ab_init",   1'b0, LOAD, 3'd0, 1'b0, 1'b0, 1'b1, S_INIT | RS);
      cyc("ab_fetch",  1'b0, OP, 3'd0, 1'b0, 1'b0, 1'b0, S_FETCH | R1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
